// File: rtl/mriscv_axil_arbiter.sv
// rtl/mriscv_axil_arbiter.sv - N-master to 1-slave AXI4-Lite round-robin arbiter
// One transaction in flight system-wide; the granted master's channels are forwarded combinationally.
module mriscv_axil_arbiter #(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    localparam int GW       = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_MASTERS*ADDR_W-1:0]   m_awaddr,
    input  logic [N_MASTERS*3-1:0]        m_awprot,
    input  logic [N_MASTERS-1:0]          m_awvalid,
    output logic [N_MASTERS-1:0]          m_awready,
    input  logic [N_MASTERS*DATA_W-1:0]   m_wdata,
    input  logic [N_MASTERS*DATA_W/8-1:0] m_wstrb,
    input  logic [N_MASTERS-1:0]          m_wvalid,
    output logic [N_MASTERS-1:0]          m_wready,
    output logic [N_MASTERS-1:0]          m_bvalid,
    input  logic [N_MASTERS-1:0]          m_bready,
    input  logic [N_MASTERS*ADDR_W-1:0]   m_araddr,
    input  logic [N_MASTERS*3-1:0]        m_arprot,
    input  logic [N_MASTERS-1:0]          m_arvalid,
    output logic [N_MASTERS-1:0]          m_arready,
    output logic [DATA_W-1:0]             m_rdata,
    output logic [N_MASTERS-1:0]          m_rvalid,
    input  logic [N_MASTERS-1:0]          m_rready,
    output logic [ADDR_W-1:0]             s_awaddr,
    output logic [2:0]                    s_awprot,
    output logic                          s_awvalid,
    input  logic                          s_awready,
    output logic [DATA_W-1:0]             s_wdata,
    output logic [DATA_W/8-1:0]           s_wstrb,
    output logic                          s_wvalid,
    input  logic                          s_wready,
    input  logic                          s_bvalid,
    output logic                          s_bready,
    output logic [ADDR_W-1:0]             s_araddr,
    output logic [2:0]                    s_arprot,
    output logic                          s_arvalid,
    input  logic                          s_arready,
    input  logic [DATA_W-1:0]             s_rdata,
    input  logic                          s_rvalid,
    output logic                          s_rready,
    output logic [GW-1:0]                 grant,
    output logic                          busy
);

    typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR_AW, WR_B} state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   ptr_q, ptr_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic            aw_done_q, aw_done_d;
    logic            w_done_q, w_done_d;

    logic [N_MASTERS-1:0] req;
    logic                 found;
    logic [GW-1:0]        pick;
    int                   cand;
    int                   g;
    logic                 aw_hs, w_hs;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            grant_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    // First requester at or above ptr, wrapping modulo N_MASTERS.
    always_comb begin
        req   = m_awvalid | m_arvalid;
        found = 1'b0;
        pick  = '0;
        cand  = 0;
        for (int i = 0; i < N_MASTERS; i++) begin
            cand = (int'(ptr_q) + i) % N_MASTERS;
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = GW'(cand);
            end
        end
    end

    assign aw_hs = s_awvalid & s_awready;
    assign w_hs  = s_wvalid & s_wready;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = pick;
                    ptr_d   = (pick == GW'(N_MASTERS - 1)) ? '0 : pick + GW'(1);
                    state_d = m_awvalid[pick] ? WR_AW : RD_A;
                end
            end
            RD_A:  if (s_arvalid && s_arready) state_d = RD_D;
            RD_D:  if (s_rvalid && s_rready) state_d = IDLE;
            WR_AW: begin
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    state_d   = WR_B;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end else begin
                    aw_done_d = aw_done_q | aw_hs;
                    w_done_d  = w_done_q | w_hs;
                end
            end
            WR_B:  if (s_bvalid && s_bready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign g        = int'(grant_q);
    assign s_awaddr = m_awaddr[g*ADDR_W +: ADDR_W];
    assign s_awprot = m_awprot[g*3 +: 3];
    assign s_wdata  = m_wdata[g*DATA_W +: DATA_W];
    assign s_wstrb  = m_wstrb[g*(DATA_W/8) +: DATA_W/8];
    assign s_araddr = m_araddr[g*ADDR_W +: ADDR_W];
    assign s_arprot = m_arprot[g*3 +: 3];
    assign m_rdata  = s_rdata;
    assign grant    = grant_q;
    assign busy     = (state_q != IDLE);

    // Handshake signals only pass between the owner and the slave; a completed AW/W is masked.
    always_comb begin
        m_awready = '0;
        m_wready  = '0;
        m_bvalid  = '0;
        m_arready = '0;
        m_rvalid  = '0;
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        s_bready  = 1'b0;
        s_arvalid = 1'b0;
        s_rready  = 1'b0;
        unique case (state_q)
            RD_A: begin
                s_arvalid          = m_arvalid[grant_q];
                m_arready[grant_q] = s_arready;
            end
            RD_D: begin
                s_rready          = m_rready[grant_q];
                m_rvalid[grant_q] = s_rvalid;
            end
            WR_AW: begin
                s_awvalid          = m_awvalid[grant_q] & ~aw_done_q;
                m_awready[grant_q] = s_awready & ~aw_done_q;
                s_wvalid           = m_wvalid[grant_q] & ~w_done_q;
                m_wready[grant_q]  = s_wready & ~w_done_q;
            end
            WR_B: begin
                s_bready          = m_bready[grant_q];
                m_bvalid[grant_q] = s_bvalid;
            end
            default: ;
        endcase
    end

endmodule
